// File: rtl/mcycle_ctx_queue.sv
// mcycle_ctx_queue: in-order circular queue of outstanding multi-cycle instruction contexts.
//
// Each Start pushes the execute-stage context; each Done pops the oldest one. While Done is high
// and an entry is held, the context outputs show that head entry. Otherwise they pass the
// execute-stage inputs straight through. A small scoreboard reports whether any held entry
// will write the register that decode is reading.
//
// Ports:
//   CLK, Reset          clock; asynchronous active-high reset
//   Start, Done, Flush  push, pop, and discard-all controls (Flush wins)
//   InstrE .. WA3E      execute-stage context to be pushed
//   MCycleResultE       multi-cycle result, selected when Done is high
//   ALUResultE          single-cycle result, selected otherwise
//   InstrRE .. WA3RE    selected context (head on Done, else pass-through)
//   OpResultRE          selected result
//   RAAD, RABD          decode-stage source registers; HazardA/HazardB are the scoreboard hits
//   Full, Empty, Count  occupancy
//   Overflow, Underflow sticky error flags, cleared only by Reset
module mcycle_ctx_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 32,
    parameter int unsigned RW    = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Done,
    input  logic                     Flush,
    input  logic [31:0]              InstrE,
    input  logic                     RegWriteE,
    input  logic                     MemWriteE,
    input  logic                     MemtoRegE,
    input  logic [DW-1:0]            WriteDataE,
    input  logic [RW-1:0]            RA2E,
    input  logic [RW-1:0]            WA3E,
    input  logic [DW-1:0]            MCycleResultE,
    input  logic [DW-1:0]            ALUResultE,
    output logic [31:0]              InstrRE,
    output logic                     RegWriteRE,
    output logic                     MemWriteRE,
    output logic                     MemtoRegRE,
    output logic [DW-1:0]            WriteDataRE,
    output logic [RW-1:0]            RA2RE,
    output logic [RW-1:0]            WA3RE,
    output logic [DW-1:0]            OpResultRE,
    input  logic [RW-1:0]            RAAD,
    input  logic [RW-1:0]            RABD,
    output logic                     HazardA,
    output logic                     HazardB,
    output logic                     Full,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    output logic                     Underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    // Entry layout, LSB first: WA3, RA2, WriteData, MemtoReg, MemWrite, RegWrite, Instr.
    localparam int unsigned CW    = 32 + 3 + DW + 2 * RW;
    localparam int unsigned RwBit = DW + 2 * RW + 2;

    logic [CW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  rdPtr_q, rdPtr_d;
    logic [PW-1:0]  wrPtr_q, wrPtr_d;
    logic [PW:0]    count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;
    logic           doPush, doPop;
    logic           headSel;
    logic [CW-1:0]  wrEntry, headEntry;
    logic [DEPTH-1:0] valid;

    logic [31:0]    hInstr;
    logic           hRegWrite, hMemWrite, hMemtoReg;
    logic [DW-1:0]  hWriteData;
    logic [RW-1:0]  hRA2, hWA3;

    assign Empty     = (count_q == '0);
    assign Full      = (count_q == (PW + 1)'(DEPTH));
    assign Count     = count_q;
    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;

    assign wrEntry   = {InstrE, RegWriteE, MemWriteE, MemtoRegE, WriteDataE, RA2E, WA3E};
    assign headEntry = mem_q[rdPtr_q];
    assign {hInstr, hRegWrite, hMemWrite, hMemtoReg, hWriteData, hRA2, hWA3} = headEntry;

    // Next-state: a full queue refuses the push even when a pop frees a slot this cycle.
    always_comb begin
        doPush      = 1'b0;
        doPop       = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (!Flush && !Reset) begin
            doPush = Start && !Full;
            doPop  = Done && !Empty;
            if (Start && Full) begin
                overflow_d = 1'b1;
            end
            if (Done && Empty) begin
                underflow_d = 1'b1;
            end
        end
        rdPtr_d = rdPtr_q + PW'(doPop);
        wrPtr_d = wrPtr_q + PW'(doPush);
        count_d = count_q + (PW + 1)'(doPush) - (PW + 1)'(doPop);
        if (Flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; the valid mask keeps stale entries invisible.
    always_ff @(posedge CLK) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wrEntry;
        end
    end

    // Output select
    always_comb begin
        headSel = Done && !Empty;
        if (headSel) begin
            InstrRE     = hInstr;
            RegWriteRE  = hRegWrite;
            MemWriteRE  = hMemWrite;
            MemtoRegRE  = hMemtoReg;
            WriteDataRE = hWriteData;
            RA2RE       = hRA2;
            WA3RE       = hWA3;
        end else begin
            InstrRE     = InstrE;
            RegWriteRE  = RegWriteE;
            MemWriteRE  = MemWriteE;
            MemtoRegRE  = MemtoRegE;
            WriteDataRE = WriteDataE;
            RA2RE       = RA2E;
            WA3RE       = WA3E;
        end
        OpResultRE = Done ? MCycleResultE : ALUResultE;
    end

    // Scoreboard on registered state only: a head popped this cycle still hits, a push does not.
    always_comb begin
        logic [PW-1:0] off;
        valid   = '0;
        HazardA = 1'b0;
        HazardB = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            off      = PW'(i) - rdPtr_q;
            valid[i] = ({1'b0, off} < count_q);
            if (valid[i] && mem_q[i][RwBit]) begin
                if (mem_q[i][RW-1:0] == RAAD) begin
                    HazardA = 1'b1;
                end
                if (mem_q[i][RW-1:0] == RABD) begin
                    HazardB = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcycle_ctx_queue.sv
// Self-checking bench for mcycle_ctx_queue: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_mcycle_ctx_queue;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned RW    = 4;
    localparam int unsigned CNTW  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0]   instr;
        logic          rw;
        logic          mw;
        logic          m2r;
        logic [DW-1:0] wd;
        logic [RW-1:0] ra2;
        logic [RW-1:0] wa3;
    } ctx_t;

    logic            CLK = 1'b0;
    logic            Reset;
    logic            Start, Done, Flush;
    logic [31:0]     InstrE;
    logic            RegWriteE, MemWriteE, MemtoRegE;
    logic [DW-1:0]   WriteDataE;
    logic [RW-1:0]   RA2E, WA3E;
    logic [DW-1:0]   MCycleResultE, ALUResultE;
    logic [31:0]     InstrRE;
    logic            RegWriteRE, MemWriteRE, MemtoRegRE;
    logic [DW-1:0]   WriteDataRE;
    logic [RW-1:0]   RA2RE, WA3RE;
    logic [DW-1:0]   OpResultRE;
    logic [RW-1:0]   RAAD, RABD;
    logic            HazardA, HazardB;
    logic            Full, Empty;
    logic [CNTW-1:0] Count;
    logic            Overflow, Underflow;

    int tests = 0;
    int fails = 0;

    mcycle_ctx_queue #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Start        (Start),
        .Done         (Done),
        .Flush        (Flush),
        .InstrE       (InstrE),
        .RegWriteE    (RegWriteE),
        .MemWriteE    (MemWriteE),
        .MemtoRegE    (MemtoRegE),
        .WriteDataE   (WriteDataE),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .MCycleResultE(MCycleResultE),
        .ALUResultE   (ALUResultE),
        .InstrRE      (InstrRE),
        .RegWriteRE   (RegWriteRE),
        .MemWriteRE   (MemWriteRE),
        .MemtoRegRE   (MemtoRegRE),
        .WriteDataRE  (WriteDataRE),
        .RA2RE        (RA2RE),
        .WA3RE        (WA3RE),
        .OpResultRE   (OpResultRE),
        .RAAD         (RAAD),
        .RABD         (RABD),
        .HazardA      (HazardA),
        .HazardB      (HazardB),
        .Full         (Full),
        .Empty        (Empty),
        .Count        (Count),
        .Overflow     (Overflow),
        .Underflow    (Underflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ctx_t curCtx();
        ctx_t c;
        c = '{instr: InstrE, rw: RegWriteE, mw: MemWriteE, m2r: MemtoRegE, wd: WriteDataE,
              ra2: RA2E, wa3: WA3E};
        return c;
    endfunction

    // Reference model: a queue of held contexts plus the two sticky flags.
    ctx_t mq[$];
    logic mOvf = 1'b0;
    logic mUnf = 1'b0;

    initial forever begin
        int n;
        @(posedge CLK or posedge Reset);
        if (Reset) begin
            mq.delete();
            mOvf = 1'b0;
            mUnf = 1'b0;
        end else if (Flush) begin
            mq.delete();
        end else begin
            n = mq.size();
            if (Start && n == int'(DEPTH)) mOvf = 1'b1;
            if (Done && n == 0) mUnf = 1'b1;
            if (Done && n > 0) void'(mq.pop_front());
            if (Start && n < int'(DEPTH)) mq.push_back(curCtx());
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        int   n;
        ctx_t h;
        logic hA, hB;
        @(negedge CLK);
        n  = mq.size();
        h  = (Done && n > 0) ? mq[0] : curCtx();
        hA = 1'b0;
        hB = 1'b0;
        foreach (mq[k]) begin
            if (mq[k].rw && mq[k].wa3 == RAAD) hA = 1'b1;
            if (mq[k].rw && mq[k].wa3 == RABD) hB = 1'b1;
        end
        chk("m_Count",      64'(Count),       64'(n));
        chk("m_Empty",      64'(Empty),       64'(n == 0));
        chk("m_Full",       64'(Full),        64'(n == int'(DEPTH)));
        chk("m_Overflow",   64'(Overflow),    64'(mOvf));
        chk("m_Underflow",  64'(Underflow),   64'(mUnf));
        chk("m_InstrRE",    64'(InstrRE),     64'(h.instr));
        chk("m_RegWriteRE", 64'(RegWriteRE),  64'(h.rw));
        chk("m_MemWriteRE", 64'(MemWriteRE),  64'(h.mw));
        chk("m_MemtoRegRE", 64'(MemtoRegRE),  64'(h.m2r));
        chk("m_WriteDataRE", 64'(WriteDataRE), 64'(h.wd));
        chk("m_RA2RE",      64'(RA2RE),       64'(h.ra2));
        chk("m_WA3RE",      64'(WA3RE),       64'(h.wa3));
        chk("m_OpResultRE", 64'(OpResultRE),  64'(Done ? MCycleResultE : ALUResultE));
        chk("m_HazardA",    64'(HazardA),     64'(hA));
        chk("m_HazardB",    64'(HazardB),     64'(hB));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        Start = 0; Done = 0; Flush = 0;
        InstrE = '0; RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0;
        WriteDataE = '0; RA2E = '0; WA3E = '0;
        MCycleResultE = '0; ALUResultE = '0; RAAD = '0; RABD = '0;
    endtask

    // Advance to the input-drive point of the next cycle.
    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [RW-1:0] wa3, input logic [31:0] instr);
        idle();
        Start = 1; WA3E = wa3; RegWriteE = 1; InstrE = instr;
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        @(negedge CLK);
        chk("rst_Count", 64'(Count), 64'd0);
        chk("rst_Empty", 64'(Empty), 64'd1);
        chk("rst_Full",  64'(Full),  64'd0);
        chk("rst_Ovf",   64'(Overflow), 64'd0);
        #1 Reset = 1'b0;
        nxt();

        // Single op: push WA3=5, three idle cycles, then complete.
        push(4'd5, 32'h0000_00A5);
        nxt(); idle();
        @(negedge CLK); chk("op_Count1", 64'(Count), 64'd1);
        nxt(); nxt(); nxt();
        Done = 1; MCycleResultE = 32'h1234; ALUResultE = 32'hBEEF;
        @(negedge CLK);
        chk("op_WA3RE", 64'(WA3RE), 64'd5);
        chk("op_RegWriteRE", 64'(RegWriteRE), 64'd1);
        chk("op_OpResultRE", 64'(OpResultRE), 64'h1234);
        nxt(); idle();
        @(negedge CLK); chk("op_Count0", 64'(Count), 64'd0);

        // Overflow: A, B, then C refused.
        nxt(); push(4'd1, 32'hA);
        nxt(); push(4'd2, 32'hB);
        nxt(); push(4'd3, 32'hC);
        nxt(); idle();
        @(negedge CLK);
        chk("ovf_Overflow", 64'(Overflow), 64'd1);
        chk("ovf_Count", 64'(Count), 64'd2);
        nxt(); Done = 1;
        @(negedge CLK); chk("ovf_popA", 64'(InstrRE), 64'hA);
        nxt(); Done = 1;
        @(negedge CLK); chk("ovf_popB", 64'(InstrRE), 64'hB);
        nxt(); idle();

        // Simultaneous push/pop with one entry held.
        push(4'd7, 32'h7);
        nxt(); push(4'd9, 32'h9); Done = 1;
        @(negedge CLK);
        chk("pp_Count", 64'(Count), 64'd1);
        chk("pp_oldHead", 64'(WA3RE), 64'd7);
        nxt(); idle(); Done = 1;
        @(negedge CLK); chk("pp_newHead", 64'(WA3RE), 64'd9);
        nxt(); idle();

        // Scoreboard.
        push(4'd3, 32'h3);
        nxt(); idle(); RAAD = 4'd3; RABD = 4'd4;
        @(negedge CLK);
        chk("hz_A", 64'(HazardA), 64'd1);
        chk("hz_B", 64'(HazardB), 64'd0);
        nxt(); Done = 1;
        @(negedge CLK); chk("hz_A_popcycle", 64'(HazardA), 64'd1);
        nxt(); Done = 0;
        @(negedge CLK);
        chk("hz_A_after", 64'(HazardA), 64'd0);
        chk("hz_B_after", 64'(HazardB), 64'd0);

        // Start and Done on an empty queue: pass-through plus underflow.
        nxt(); push(4'd6, 32'h66); Done = 1;
        @(negedge CLK);
        chk("uf_pass_WA3", 64'(WA3RE), 64'd6);
        chk("uf_pass_Instr", 64'(InstrRE), 64'h66);
        nxt(); idle();
        @(negedge CLK);
        chk("uf_Underflow", 64'(Underflow), 64'd1);
        chk("uf_Count", 64'(Count), 64'd1);

        // Flush with Start while full.
        nxt(); push(4'd8, 32'h8);
        nxt(); push(4'd2, 32'h2); Flush = 1;
        nxt(); idle();
        @(negedge CLK);
        chk("fl_Count", 64'(Count), 64'd0);
        chk("fl_Empty", 64'(Empty), 64'd1);
        chk("fl_Overflow", 64'(Overflow), 64'd1);

        // Asynchronous reset mid-cycle with two entries held.
        nxt(); push(4'd1, 32'h1);
        nxt(); push(4'd2, 32'h2);
        nxt(); idle(); Done = 1;
        #2 Reset = 1'b1;
        #1;
        chk("ar_Count", 64'(Count), 64'd0);
        chk("ar_Empty", 64'(Empty), 64'd1);
        chk("ar_Overflow", 64'(Overflow), 64'd0);
        chk("ar_Underflow", 64'(Underflow), 64'd0);
        @(negedge CLK); #1 Reset = 1'b0;
        nxt(); idle();
        @(negedge CLK); chk("ar_Count_after", 64'(Count), 64'd0);

        // Randomized traffic, small register space so hazards hit often.
        for (int c = 0; c < 3000; c++) begin
            nxt();
            Start         = 1'($urandom_range(0, 1));
            Done          = 1'($urandom_range(0, 1));
            Flush         = ($urandom_range(0, 31) == 0);
            InstrE        = $urandom;
            RegWriteE     = 1'($urandom_range(0, 1));
            MemWriteE     = 1'($urandom_range(0, 1));
            MemtoRegE     = 1'($urandom_range(0, 1));
            WriteDataE    = $urandom;
            RA2E          = RW'($urandom_range(0, 15));
            WA3E          = RW'($urandom_range(0, 3));
            MCycleResultE = $urandom;
            ALUResultE    = $urandom;
            RAAD          = RW'($urandom_range(0, 3));
            RABD          = RW'($urandom_range(0, 3));
            if ($urandom_range(0, 127) == 0) begin
                #1 Reset = 1'b1;
                #1 Reset = 1'b0;
            end
        end
        nxt(); idle();
        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
